// File: rtl/sd_deser_n.sv
// N:1 deserializer: reassembles ratio narrow beats (first beat flagged) into one
// wide word on a registered srdy/drdy producer port, recovering from framing slips.
module sd_deser_n #(
    parameter int width = 16,
    parameter int ratio = 4,
    parameter int cw    = $clog2(ratio)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     c_srdy,
    output logic                     c_drdy,
    input  logic                     c_first,
    input  logic [width/ratio-1:0]   c_data,
    output logic                     p_srdy,
    input  logic                     p_drdy,
    output logic [width-1:0]         p_data,
    output logic                     err_frame
);

    localparam int BW = width / ratio;
    localparam logic [cw-1:0] CNT_LAST = cw'(ratio - 1);
    localparam logic [cw-1:0] CNT_ZERO = '0;
    localparam logic [cw-1:0] CNT_ONE  = cw'(1);

    logic [cw-1:0]       cnt_reg;
    logic [cw-1:0]       cnt_next;
    logic [width-BW-1:0] acc_reg;
    logic                p_srdy_reg;
    logic [width-1:0]    p_data_reg;
    logic                err_reg;

    logic is_last;
    logic is_zero;
    logic accept;
    logic beat_start;
    logic beat_mid;
    logic beat_load;
    logic err_a;
    logic err_b;

    assign is_last = (cnt_reg == CNT_LAST);
    assign is_zero = (cnt_reg == CNT_ZERO);

    // Only a beat that would complete a word waits on the output register; a
    // misframed first beat at the last slot is an error and is never stalled.
    assign c_drdy = (is_last && !c_first) ? (!p_srdy_reg || p_drdy) : 1'b1;
    assign accept = c_srdy && c_drdy;

    assign beat_start = accept && c_first;
    assign beat_mid   = accept && !c_first && !is_zero && !is_last;
    assign beat_load  = accept && !c_first && is_last;
    assign err_a      = accept && c_first && !is_zero;
    assign err_b      = accept && !c_first && is_zero;

    always_comb begin
        cnt_next = cnt_reg;
        if (beat_start) begin
            cnt_next = CNT_ONE;
        end else if (beat_mid) begin
            cnt_next = cnt_reg + CNT_ONE;
        end else if (beat_load) begin
            cnt_next = CNT_ZERO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_a || err_b;
        end
    end

    // Slice 0 is rewritten by every first beat, which also discards a partial word.
    generate
        for (genvar gi = 0; gi < ratio - 1; gi++) begin : g_acc
            logic slice_wr;
            if (gi == 0) begin : g_first
                assign slice_wr = beat_start;
            end else begin : g_rest
                assign slice_wr = beat_mid && (cnt_reg == cw'(gi));
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_reg[gi*BW +: BW] <= '0;
                end else if (slice_wr) begin
                    acc_reg[gi*BW +: BW] <= c_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_srdy_reg <= 1'b0;
            p_data_reg <= '0;
        end else if (beat_load) begin
            p_srdy_reg <= 1'b1;
            p_data_reg <= {c_data, acc_reg};
        end else if (p_drdy) begin
            p_srdy_reg <= 1'b0;
        end
    end

    assign p_srdy    = p_srdy_reg;
    assign p_data    = p_data_reg;
    assign err_frame = err_reg;

endmodule

// File: tb/tb_sd_deser_n.sv
// Randomized and directed bench for sd_deser_n (width=16, ratio=4), checked against
// a word-level framing model built from the logged accepted beats.
module tb_sd_deser_n;

    localparam int WIDTH = 16;
    localparam int RATIO = 4;
    localparam int BW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             c_srdy;
    logic             c_drdy;
    logic             c_first;
    logic [BW-1:0]    c_data;
    logic             p_srdy;
    logic             p_drdy = 1'b1;
    logic [WIDTH-1:0] p_data;
    logic             err_frame;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit pd_rand = 1'b0;
    bit pd_val  = 1'b1;

    logic [BW-1:0]    beat_d[$];
    bit               beat_f[$];
    int               beat_c[$];
    logic [WIDTH-1:0] obs_w[$];
    int               obs_c[$];
    logic [WIDTH-1:0] exp_q[$];
    int               err_cnt   = 0;
    int               stab_viol = 0;
    bit               prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    sd_deser_n #(.width(WIDTH), .ratio(RATIO)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy),
        .c_first   (c_first),
        .c_data    (c_data),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .p_data    (p_data),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        p_drdy = pd_rand ? 1'($urandom_range(0, 1)) : pd_val;
    end

    // Passive monitor: logs transfers, error pulses and output-hold violations.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!p_srdy || p_data !== prev_data)) stab_viol++;
            prev_hold = p_srdy && !p_drdy;
            prev_data = p_data;
            if (p_srdy && p_drdy) begin
                obs_w.push_back(p_data);
                obs_c.push_back(cyc);
            end
            if (err_frame) err_cnt++;
            if (c_srdy && c_drdy) begin
                beat_d.push_back(c_data);
                beat_f.push_back(c_first);
                beat_c.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        beat_d.delete();
        beat_f.delete();
        beat_c.delete();
        obs_w.delete();
        obs_c.delete();
        err_cnt   = 0;
        stab_viol = 0;
        prev_hold = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns just after the edge that took the beat.
    task automatic drive_beat(input logic [BW-1:0] d, input bit f);
        int n = 0;
        c_srdy  = 1'b1;
        c_data  = d;
        c_first = f;
        @(negedge clk);
        while (!c_drdy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!c_drdy) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout data=%h c_drdy=%b required 1", d, c_drdy);
        end
        @(posedge clk);
        #1;
        c_srdy  = 1'b0;
        c_data  = BW'($urandom);
        c_first = 1'($urandom);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int k = 0; k < RATIO; k++) drive_beat(w[k*BW +: BW], k == 0);
    endtask

    // Word-level framing rules: a first beat restarts the word, a stray beat with
    // no word open is dropped, and every RATIO collected beats make one word.
    task automatic run_model(output int nerr);
        logic [BW-1:0]    part[$];
        logic [WIDTH-1:0] w;
        exp_q.delete();
        nerr = 0;
        foreach (beat_d[i]) begin
            if (beat_f[i]) begin
                if (part.size() != 0) nerr++;
                part.delete();
                part.push_back(beat_d[i]);
            end else if (part.size() == 0) begin
                nerr++;
            end else begin
                part.push_back(beat_d[i]);
            end
            if (part.size() == RATIO) begin
                w = '0;
                for (int k = 0; k < RATIO; k++) w = w | (WIDTH'(part[k]) << (k * BW));
                exp_q.push_back(w);
                part.delete();
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        c_srdy  = 1'b0;
        c_first = 1'b0;
        c_data  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (p_srdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_p_srdy got=%b required 0", p_srdy);
        end
        checks++;
        if (p_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_p_data got=%h required 0000", p_data);
        end
        checks++;
        if (err_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_err_frame got=%b required 0", err_frame);
        end
        checks++;
        if (c_drdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_c_drdy got=%b required 1", c_drdy);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        idle(2);
        clear_logs();
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words[100];
        int bad_gap = 0;
        pd_rand = 1'b0;
        pd_val  = 1'b1;
        idle(2);
        clear_logs();
        foreach (words[i]) words[i] = (i == 0) ? 16'h4321 : WIDTH'($urandom);
        foreach (words[i]) send_word(words[i]);
        idle(4);
        checks++;
        if (obs_w.size() != 100) begin
            failures++;
            $display("FAIL stream_count got=%0d required 100", obs_w.size());
        end else begin
            foreach (words[i]) begin
                checks++;
                if (obs_w[i] !== words[i]) begin
                    failures++;
                    $display("FAIL stream_word[%0d] got=%h required %h", i, obs_w[i], words[i]);
                end
            end
            checks++;
            if (obs_c[0] != beat_c[3] + 1) begin
                failures++;
                $display("FAIL stream_latency got_cycle=%0d required %0d", obs_c[0], beat_c[3] + 1);
            end
            for (int i = 1; i < 100; i++) if (obs_c[i] - obs_c[i-1] != RATIO) bad_gap++;
            checks++;
            if (bad_gap != 0) begin
                failures++;
                $display("FAIL stream_throughput irregular_gaps=%0d required 0", bad_gap);
            end
        end
        checks++;
        if (err_cnt != 0) begin
            failures++;
            $display("FAIL stream_err_frame got=%0d required 0", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        int hi = 0;
        pd_val = 1'b0;
        idle(2);
        clear_logs();
        send_word(16'h4321);
        drive_beat(4'h5, 1'b1);
        drive_beat(4'h6, 1'b0);
        drive_beat(4'h7, 1'b0);
        c_srdy  = 1'b1;
        c_data  = 4'h8;
        c_first = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (c_drdy) hi++;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL bp_last_beat_stall c_drdy_high_cycles=%0d required 0", hi);
        end
        checks++;
        if (p_srdy !== 1'b1 || p_data !== 16'h4321) begin
            failures++;
            $display("FAIL bp_held_word got=%b/%h required 1/4321", p_srdy, p_data);
        end
        pd_val = 1'b1;
        drive_beat(4'h8, 1'b0);
        idle(4);
        checks++;
        if (obs_w.size() != 2) begin
            failures++;
            $display("FAIL bp_count got=%0d required 2", obs_w.size());
        end else begin
            checks++;
            if (obs_w[0] !== 16'h4321 || obs_w[1] !== 16'h8765) begin
                failures++;
                $display("FAIL bp_words got=%h,%h required 4321,8765", obs_w[0], obs_w[1]);
            end
            checks++;
            if (obs_c[1] != obs_c[0] + 1) begin
                failures++;
                $display("FAIL bp_second_latency got_cycle=%0d required %0d", obs_c[1], obs_c[0] + 1);
            end
        end
        checks++;
        if (stab_viol != 0 || beat_d.size() != 8) begin
            failures++;
            $display("FAIL bp_stability viol=%0d beats=%0d required 0/8", stab_viol, beat_d.size());
        end
    endtask

    task automatic test_frame_a();
        clear_logs();
        drive_beat(4'hA, 1'b1);
        drive_beat(4'hB, 1'b0);
        send_word(16'h4321);
        idle(4);
        checks++;
        if (obs_w.size() != 1 || obs_w[0] !== 16'h4321) begin
            failures++;
            $display("FAIL frame_a_output count=%0d first=%h required 1/4321",
                     obs_w.size(), (obs_w.size() != 0) ? obs_w[0] : 16'hxxxx);
        end
        checks++;
        if (err_cnt != 1) begin
            failures++;
            $display("FAIL frame_a_err_pulses got=%0d required 1", err_cnt);
        end
    endtask

    task automatic test_frame_b();
        clear_logs();
        drive_beat(4'h9, 1'b0);
        send_word(16'h4321);
        idle(4);
        checks++;
        if (obs_w.size() != 1 || obs_w[0] !== 16'h4321) begin
            failures++;
            $display("FAIL frame_b_output count=%0d first=%h required 1/4321",
                     obs_w.size(), (obs_w.size() != 0) ? obs_w[0] : 16'hxxxx);
        end
        checks++;
        if (err_cnt != 1) begin
            failures++;
            $display("FAIL frame_b_err_pulses got=%0d required 1", err_cnt);
        end
    endtask

    task automatic test_midword_reset();
        pd_val = 1'b0;
        idle(2);
        clear_logs();
        send_word(16'h4321);
        drive_beat(4'h5, 1'b1);
        drive_beat(4'h6, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (p_srdy !== 1'b0 || p_data !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%h required 0/0000", p_srdy, p_data);
        end
        pd_val = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        clear_logs();
        idle(1);
        send_word(16'hDCBA);
        idle(4);
        checks++;
        if (obs_w.size() != 1 || obs_w[0] !== 16'hDCBA) begin
            failures++;
            $display("FAIL midreset_word count=%0d first=%h required 1/dcba",
                     obs_w.size(), (obs_w.size() != 0) ? obs_w[0] : 16'hxxxx);
        end
        checks++;
        if (err_cnt != 0) begin
            failures++;
            $display("FAIL midreset_err_frame got=%0d required 0", err_cnt);
        end
    endtask

    task automatic test_random();
        int n_words = 400;
        int r;
        int nb;
        int nerr;
        logic [WIDTH-1:0] w;
        clear_logs();
        pd_rand = 1'b1;
        for (int i = 0; i < n_words; i++) begin
            r  = (i == n_words - 1) ? 5 : int'($urandom_range(0, 19));
            w  = WIDTH'($urandom);
            if (r == 0) drive_beat(BW'($urandom), 1'b0);
            nb = (r == 1) ? int'($urandom_range(1, RATIO - 1)) : RATIO;
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                drive_beat(w[k*BW +: BW], k == 0);
            end
        end
        pd_rand = 1'b0;
        pd_val  = 1'b1;
        idle(10);
        run_model(nerr);
        checks++;
        if (obs_w.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d required %0d", obs_w.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_w[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_word[%0d] got=%h required %h", i, obs_w[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_cnt != nerr) begin
            failures++;
            $display("FAIL random_err_pulses got=%0d required %0d", err_cnt, nerr);
        end
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL random_output_hold violations=%0d required 0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_frame_a();
        test_frame_b();
        test_midword_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
